ppu_vram_responder: RTL and testbench



---
 rtl/ppu_vram_responder.sv | 215 +++++++++++++++++++++
 tb/tb_ppu_vram_responder.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_responder.sv
// ppu_vram_responder
//   Arbitrates background and sprite fetcher reads onto a single VRAM port
//   (sprite wins) and serves OAM flag reads on an independent, fully
//   pipelined channel. The VRAM and OAM block RAMs return data READ_LATENCY
//   cycles after the read strobe. Accesses that fall outside VRAM or OAM
//   return 8'hFF with the same timing and never strobe the RAM.
//
// Ports
//   clk_in, rst_in          : clock, synchronous active-high reset
//   bg_addr_in/_valid_in    : background request (address + one-cycle pulse)
//   bg_data_out/_valid_out  : background response (data + one-cycle pulse)
//   spr_addr_in/_valid_in   : sprite request
//   spr_data_out/_valid_out : sprite response
//   flag_addr_in, flag_request_in       : OAM flag request
//   sprite_flags_out, valid_flags_out   : OAM flag response
//   mem_free_out            : high when no background read is pending/in flight
//   spr_stall_count_out     : (PPU_VRAM_STATS_EN only) saturating count of
//                             cycles the background request waits on a busy
//                             port or a sprite issue
//   vram_addr_out/_rd_out, vram_data_in : VRAM block RAM port
//   oam_addr_out/_rd_out, oam_data_in   : OAM block RAM port
//
// Build option
//   PPU_VRAM_STATS_EN : adds spr_stall_count_out and its counter.

module ppu_vram_responder #(
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [15:0] VRAM_BASE    = 16'h8000,
  parameter logic [15:0] OAM_BASE     = 16'hFE00
) (
  input  logic        clk_in,
  input  logic        rst_in,

  input  logic [15:0] bg_addr_in,
  input  logic        bg_addr_valid_in,
  output logic [7:0]  bg_data_out,
  output logic        bg_data_valid_out,

  input  logic [15:0] spr_addr_in,
  input  logic        spr_addr_valid_in,
  output logic [7:0]  spr_data_out,
  output logic        spr_data_valid_out,

  input  logic [15:0] flag_addr_in,
  input  logic        flag_request_in,
  output logic [7:0]  sprite_flags_out,
  output logic        valid_flags_out,

  output logic        mem_free_out,
`ifdef PPU_VRAM_STATS_EN
  output logic [15:0] spr_stall_count_out,
`endif

  output logic [12:0] vram_addr_out,
  output logic        vram_rd_out,
  input  logic [7:0]  vram_data_in,

  output logic [7:0]  oam_addr_out,
  output logic        oam_rd_out,
  input  logic [7:0]  oam_data_in
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BG_WAIT  = 2'd1,
    SPR_WAIT = 2'd2
  } state_t;

  localparam logic [1:0]  CNT_LAST  = 2'(READ_LATENCY - 1);
  localparam logic [15:0] VRAM_SIZE = 16'h2000;
  localparam logic [15:0] OAM_SIZE  = 16'd160;

  state_t      state;
  logic        bg_pend;
  logic        spr_pend;
  logic [15:0] bg_addr_q;
  logic [15:0] spr_addr_q;
  logic [1:0]  wait_cnt;
  logic        wait_oor;

  logic        spr_req;
  logic        bg_req;
  logic [15:0] spr_addr_eff;
  logic [15:0] bg_addr_eff;
  logic        issue_spr;
  logic        issue_bg;
  logic [15:0] issue_off;
  logic        issue_in_range;

  logic [15:0] flag_off;
  logic        flag_in_range;
  logic [READ_LATENCY-1:0] flag_pipe_v;
  logic [READ_LATENCY-1:0] flag_pipe_oor;

  // Request pulses bypass the pending registers so that an IDLE FSM issues
  // them in the same cycle they arrive; a fresh pulse also supersedes any
  // address already latched for that requester.
  always_comb begin
    spr_req        = spr_pend | spr_addr_valid_in;
    bg_req         = bg_pend  | bg_addr_valid_in;
    spr_addr_eff   = spr_addr_valid_in ? spr_addr_in : spr_addr_q;
    bg_addr_eff    = bg_addr_valid_in  ? bg_addr_in  : bg_addr_q;
    issue_spr      = !rst_in && (state == IDLE) && spr_req;
    issue_bg       = !rst_in && (state == IDLE) && !spr_req && bg_req;
    issue_off      = (issue_spr ? spr_addr_eff : bg_addr_eff) - VRAM_BASE;
    // Unsigned offset compare also rejects addresses below the base.
    issue_in_range = issue_off < VRAM_SIZE;
    vram_rd_out    = (issue_spr | issue_bg) & issue_in_range;
    vram_addr_out  = vram_rd_out ? issue_off[12:0] : '0;
    mem_free_out   = !(bg_pend || (state == BG_WAIT));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state              <= IDLE;
      bg_pend            <= 1'b0;
      spr_pend           <= 1'b0;
      bg_addr_q          <= '0;
      spr_addr_q         <= '0;
      wait_cnt           <= '0;
      wait_oor           <= 1'b0;
      bg_data_out        <= '0;
      bg_data_valid_out  <= 1'b0;
      spr_data_out       <= '0;
      spr_data_valid_out <= 1'b0;
    end else begin
      bg_data_valid_out  <= 1'b0;
      spr_data_valid_out <= 1'b0;

      if (spr_addr_valid_in) begin
        spr_addr_q <= spr_addr_in;
      end
      if (issue_spr) begin
        spr_pend <= 1'b0;
      end else if (spr_addr_valid_in) begin
        spr_pend <= 1'b1;
      end

      if (bg_addr_valid_in) begin
        bg_addr_q <= bg_addr_in;
      end
      if (issue_bg) begin
        bg_pend <= 1'b0;
      end else if (bg_addr_valid_in) begin
        bg_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (issue_spr || issue_bg) begin
            state    <= issue_spr ? SPR_WAIT : BG_WAIT;
            wait_cnt <= '0;
            wait_oor <= !issue_in_range;
          end
        end
        BG_WAIT, SPR_WAIT: begin
          if (wait_cnt == CNT_LAST) begin
            if (state == SPR_WAIT) begin
              spr_data_out       <= wait_oor ? 8'hFF : vram_data_in;
              spr_data_valid_out <= 1'b1;
            end else begin
              bg_data_out        <= wait_oor ? 8'hFF : vram_data_in;
              bg_data_valid_out  <= 1'b1;
            end
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PPU_VRAM_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      spr_stall_count_out <= '0;
    end else if (bg_pend && ((state != IDLE) || issue_spr) &&
                 (spr_stall_count_out != '1)) begin
      spr_stall_count_out <= spr_stall_count_out + 16'd1;
    end
  end
`endif

  // OAM flag channel: a shift register of valid/out-of-range tags tracks
  // each request so back-to-back pulses each get exactly one response.
  always_comb begin
    flag_off      = flag_addr_in - OAM_BASE;
    flag_in_range = flag_off < OAM_SIZE;
    oam_rd_out    = !rst_in && flag_request_in && flag_in_range;
    oam_addr_out  = oam_rd_out ? flag_off[7:0] : '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      flag_pipe_v      <= '0;
      flag_pipe_oor    <= '0;
      sprite_flags_out <= '0;
      valid_flags_out  <= 1'b0;
    end else begin
      flag_pipe_v[0]   <= flag_request_in;
      flag_pipe_oor[0] <= !flag_in_range;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        flag_pipe_v[i]   <= flag_pipe_v[i-1];
        flag_pipe_oor[i] <= flag_pipe_oor[i-1];
      end
      valid_flags_out <= flag_pipe_v[READ_LATENCY-1];
      if (flag_pipe_v[READ_LATENCY-1]) begin
        sprite_flags_out <= flag_pipe_oor[READ_LATENCY-1] ? 8'hFF : oam_data_in;
      end
    end
  end

endmodule

// File: tb/tb_ppu_vram_responder.sv
module tb_ppu_vram_responder;

  localparam int unsigned L = 2;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bg_addr;
  logic        bg_valid;
  logic [7:0]  bg_data;
  logic        bg_data_valid;
  logic [15:0] spr_addr;
  logic        spr_valid;
  logic [7:0]  spr_data;
  logic        spr_data_valid;
  logic [15:0] flag_addr;
  logic        flag_req;
  logic [7:0]  flags;
  logic        flags_valid;
  logic        mem_free;
  logic [12:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_data;
  logic [7:0]  oam_addr;
  logic        oam_rd;
  logic [7:0]  oam_data;
`ifdef PPU_VRAM_STATS_EN
  logic [15:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] vmem [0:8191];
  logic [7:0] omem [0:255];
  logic [7:0] vpipe [0:3];
  logic [7:0] opipe [0:3];

  exp_t bg_q[$];
  exp_t spr_q[$];
  exp_t flag_q[$];

  ppu_vram_responder #(
    .READ_LATENCY(L),
    .VRAM_BASE(16'h8000),
    .OAM_BASE(16'hFE00)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bg_addr_in(bg_addr),
    .bg_addr_valid_in(bg_valid),
    .bg_data_out(bg_data),
    .bg_data_valid_out(bg_data_valid),
    .spr_addr_in(spr_addr),
    .spr_addr_valid_in(spr_valid),
    .spr_data_out(spr_data),
    .spr_data_valid_out(spr_data_valid),
    .flag_addr_in(flag_addr),
    .flag_request_in(flag_req),
    .sprite_flags_out(flags),
    .valid_flags_out(flags_valid),
    .mem_free_out(mem_free),
`ifdef PPU_VRAM_STATS_EN
    .spr_stall_count_out(stall_count),
`endif
    .vram_addr_out(vram_addr),
    .vram_rd_out(vram_rd),
    .vram_data_in(vram_data),
    .oam_addr_out(oam_addr),
    .oam_rd_out(oam_rd),
    .oam_data_in(oam_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: data is on the bus exactly L cycles after the strobe cycle;
  // filler 8'hEE appears whenever no read was issued.
  always @(posedge clk) begin
    vpipe[0] <= vram_rd ? vmem[vram_addr] : 8'hEE;
    opipe[0] <= oam_rd ? omem[oam_addr] : 8'hEE;
    for (int i = 1; i < 4; i++) begin
      vpipe[i] <= vpipe[i-1];
      opipe[i] <= opipe[i-1];
    end
  end
  assign vram_data = vpipe[L-1];
  assign oam_data  = opipe[L-1];

  // Scoreboard monitors
  always @(negedge clk) begin
    exp_t e;
    if (bg_data_valid) begin
      checks++;
      if (bg_q.size() == 0) begin
        errors++;
        $display("FAIL bg_unexpected cyc=%0d data=%02h", cyc, bg_data);
      end else begin
        e = bg_q.pop_front();
        if (bg_data !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL bg_data got %02h@%0d want %02h@%0d", bg_data, cyc, e.data, e.cyc);
        end
      end
    end
    if (spr_data_valid) begin
      checks++;
      if (spr_q.size() == 0) begin
        errors++;
        $display("FAIL spr_unexpected cyc=%0d data=%02h", cyc, spr_data);
      end else begin
        e = spr_q.pop_front();
        if (spr_data !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL spr_data got %02h@%0d want %02h@%0d", spr_data, cyc, e.data, e.cyc);
        end
      end
    end
    if (flags_valid) begin
      checks++;
      if (flag_q.size() == 0) begin
        errors++;
        $display("FAIL flag_unexpected cyc=%0d data=%02h", cyc, flags);
      end else begin
        e = flag_q.pop_front();
        if (flags !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL flag_data got %02h@%0d want %02h@%0d", flags, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bg_valid  = 1'b0;
    spr_valid = 1'b0;
    flag_req  = 1'b0;
  endtask

  task automatic wait_drain;
    int n = 0;
    while ((bg_q.size() + spr_q.size() + flag_q.size()) != 0 && n < 40) begin
      next_cycle();
      n++;
    end
    checks++;
    if ((bg_q.size() + spr_q.size() + flag_q.size()) != 0) begin
      errors++;
      $display("FAIL drain_timeout pending bg=%0d spr=%0d flag=%0d want 0",
               bg_q.size(), spr_q.size(), flag_q.size());
      bg_q.delete();
      spr_q.delete();
      flag_q.delete();
    end
    repeat (4) next_cycle();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    bg_addr = '0; spr_addr = '0; flag_addr = '0;
    repeat (3) next_cycle();
    checks++;
    if ({bg_data_valid, spr_data_valid, flags_valid, vram_rd, oam_rd} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes got %05b want 00000",
               {bg_data_valid, spr_data_valid, flags_valid, vram_rd, oam_rd});
    end
    checks++;
    if ({bg_data, spr_data, flags} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data got %06h want 000000", {bg_data, spr_data, flags});
    end
    checks++;
    if (vram_addr !== 13'h0 || oam_addr !== 8'h0) begin
      errors++;
      $display("FAIL reset_addr got %04h/%02h want 0/0", vram_addr, oam_addr);
    end
    checks++;
    if (mem_free !== 1'b1) begin
      errors++;
      $display("FAIL reset_mem_free got %b want 1", mem_free);
    end
`ifdef PPU_VRAM_STATS_EN
    checks++;
    if (stall_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_stall got %0d want 0", stall_count);
    end
`endif
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_bg_read;
    int p;
    next_cycle();
    bg_addr = 16'h8010; bg_valid = 1'b1; p = cyc;
    bg_q.push_back('{vmem[16'h0010], p + L + 1});
    #1;
    checks++;
    if (vram_rd !== 1'b1 || vram_addr !== 13'h0010) begin
      errors++;
      $display("FAIL bg_issue got rd=%b addr=%04h want 1/0010", vram_rd, vram_addr);
    end
    next_cycle(); idle_inputs();
    for (int k = 1; k <= L; k++) begin
      checks++;
      if (mem_free !== 1'b0) begin
        errors++;
        $display("FAIL bg_mem_free_busy cyc=%0d got %b want 0", cyc, mem_free);
      end
      next_cycle();
    end
    checks++;
    if (mem_free !== 1'b1) begin
      errors++;
      $display("FAIL bg_mem_free_done got %b want 1", mem_free);
    end
    wait_drain();
    checks++;
    if (bg_data !== vmem[16'h0010]) begin
      errors++;
      $display("FAIL bg_hold got %02h want %02h", bg_data, vmem[16'h0010]);
    end
  endtask

  task automatic test_priority;
    int p;
    next_cycle();
    bg_addr = 16'h8000; bg_valid = 1'b1;
    spr_addr = 16'h8800; spr_valid = 1'b1; p = cyc;
    spr_q.push_back('{vmem[16'h0800], p + L + 1});
    bg_q.push_back('{vmem[16'h0000], p + 2 * (L + 1)});
    #1;
    checks++;
    if (vram_rd !== 1'b1 || vram_addr !== 13'h0800) begin
      errors++;
      $display("FAIL prio_spr_issue got rd=%b addr=%04h want 1/0800", vram_rd, vram_addr);
    end
    next_cycle(); idle_inputs();
    repeat (L) next_cycle();
    checks++;
    if (vram_rd !== 1'b1 || vram_addr !== 13'h0000 || spr_data_valid !== 1'b1) begin
      errors++;
      $display("FAIL prio_bg_issue got rd=%b addr=%04h sv=%b want 1/0000/1",
               vram_rd, vram_addr, spr_data_valid);
    end
    wait_drain();
  endtask

  task automatic test_out_of_range;
    int p;
    next_cycle();
    bg_addr = 16'h7FFF; bg_valid = 1'b1; p = cyc;
    bg_q.push_back('{8'hFF, p + L + 1});
    #1;
    checks++;
    if (vram_rd !== 1'b0) begin
      errors++;
      $display("FAIL oor_bg_rd got %b want 0", vram_rd);
    end
    next_cycle(); idle_inputs();
    wait_drain();
    spr_addr = 16'hA000; spr_valid = 1'b1; p = cyc;
    spr_q.push_back('{8'hFF, p + L + 1});
    #1;
    checks++;
    if (vram_rd !== 1'b0) begin
      errors++;
      $display("FAIL oor_spr_rd got %b want 0", vram_rd);
    end
    next_cycle(); idle_inputs();
    wait_drain();
  endtask

  task automatic test_flags;
    logic [15:0] addrs [3];
    logic [7:0]  want [3];
    logic        rd_want [3];
    addrs = '{16'hFE03, 16'hFE04, 16'hFEA0};
    want  = '{omem[3], omem[4], 8'hFF};
    rd_want = '{1'b1, 1'b1, 1'b0};
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      flag_addr = addrs[i]; flag_req = 1'b1;
      flag_q.push_back('{want[i], cyc + L + 1});
      #1;
      checks++;
      if (oam_rd !== rd_want[i] || (rd_want[i] && oam_addr !== addrs[i][7:0])) begin
        errors++;
        $display("FAIL flag_issue%0d got rd=%b addr=%02h want %b/%02h",
                 i, oam_rd, oam_addr, rd_want[i], addrs[i][7:0]);
      end
      next_cycle();
    end
    idle_inputs();
    wait_drain();
  endtask

  task automatic test_overwrite;
    int p;
    next_cycle();
    spr_addr = 16'h8100; spr_valid = 1'b1;
    bg_addr = 16'h8200; bg_valid = 1'b1; p = cyc;
    spr_q.push_back('{vmem[16'h0100], p + L + 1});
    bg_q.push_back('{vmem[16'h0020], p + 2 * (L + 1)});
    next_cycle();
    spr_valid = 1'b0;
    bg_addr = 16'h8020;
    next_cycle(); idle_inputs();
    wait_drain();
  endtask

  task automatic test_random;
    logic [15:0] a;
    logic        in_rng;
    logic        is_spr;
    int p;
    for (int i = 0; i < 8; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'h0000, 16'h7FFF))
                                      : 16'($urandom_range(16'h8000, 16'h9FFF));
      in_rng = (a >= 16'h8000) && (a <= 16'h9FFF);
      is_spr = 1'($urandom_range(0, 1));
      if (is_spr) begin
        spr_addr = a; spr_valid = 1'b1; p = cyc;
        spr_q.push_back('{in_rng ? vmem[a[12:0]] : 8'hFF, p + L + 1});
      end else begin
        bg_addr = a; bg_valid = 1'b1; p = cyc;
        bg_q.push_back('{in_rng ? vmem[a[12:0]] : 8'hFF, p + L + 1});
      end
      #1;
      checks++;
      if (vram_rd !== in_rng || (in_rng && vram_addr !== a[12:0])) begin
        errors++;
        $display("FAIL rand_issue%0d addr=%04h got rd=%b va=%04h want %b",
                 i, a, vram_rd, vram_addr, in_rng);
      end
      next_cycle(); idle_inputs();
      repeat (L + 1) next_cycle();
    end
    wait_drain();
  endtask

  task automatic test_reset_mid;
    int p;
    next_cycle();
    bg_addr = 16'h8040; bg_valid = 1'b1;
    next_cycle(); idle_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    repeat (8) next_cycle();
    checks++;
    if (mem_free !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_mem_free got %b want 1", mem_free);
    end
    // An IDLE FSM issues a new pulse immediately with normal timing.
    bg_addr = 16'h8041; bg_valid = 1'b1; p = cyc;
    bg_q.push_back('{vmem[16'h0041], p + L + 1});
    #1;
    checks++;
    if (vram_rd !== 1'b1 || vram_addr !== 13'h0041) begin
      errors++;
      $display("FAIL rstmid_reissue got rd=%b addr=%04h want 1/0041", vram_rd, vram_addr);
    end
    next_cycle(); idle_inputs();
    wait_drain();
  endtask

`ifdef PPU_VRAM_STATS_EN
  task automatic test_stall;
    logic [15:0] before;
    int p;
    next_cycle();
    before = stall_count;
    spr_addr = 16'h8300; spr_valid = 1'b1;
    bg_addr = 16'h8301; bg_valid = 1'b1; p = cyc;
    spr_q.push_back('{vmem[16'h0300], p + L + 1});
    bg_q.push_back('{vmem[16'h0301], p + 2 * (L + 1)});
    next_cycle(); idle_inputs();
    wait_drain();
    checks++;
    if (stall_count !== before + 16'(L)) begin
      errors++;
      $display("FAIL stall_count got %0d want %0d", stall_count, before + 16'(L));
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 8192; i++) vmem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) omem[i] = 8'($urandom);
    test_reset();
    test_bg_read();
    test_priority();
    test_out_of_range();
    test_flags();
    test_overwrite();
    test_random();
    test_reset_mid();
`ifdef PPU_VRAM_STATS_EN
    test_stall();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
